universal_seq_ctrl: RTL and testbench

Command sequencer for the universal shift register (enable / l_s / selector / inp / out datapath). It accepts one command over a valid/ready handshake: mode, load data and shift count. It loads the register, applies the requested number of shift cycles in the given mode, captures the register output, and returns it over a valid/ready response channel. It sits between a host/register-file master and a single universal shift register instance.

---
 rtl/universal_seq_ctrl.sv | 166 ++++++++++++++++
 tb/tb_universal_seq_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/universal_seq_ctrl.sv
// universal_seq_ctrl
//   Command sequencer for a universal shift register. Accepts one command
//   (mode, load data, shift count) over a valid/ready handshake, loads the
//   register, applies exactly `count` shift cycles in the given mode,
//   captures the register output and returns it over a valid/ready response.
//
// Optional feature macro: UNIV_CTRL_ABORT_EN
//   When defined, adds `abort` (input) and `rsp_aborted` (output). Abort
//   during LOAD/SHIFT suppresses the register enable that cycle and jumps
//   to CAPTURE; the resulting response is flagged with rsp_aborted.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready       command handshake
//   cmd_mode/data/count       selector, parallel load value, shift count
//   sr_enable/l_s/selector/inp  drive to the shift register
//   sr_out                    register output
//   rsp_valid/rsp_ready       response handshake
//   rsp_data                  captured register output
//   busy                      high whenever not IDLE
//   abort, rsp_aborted        (UNIV_CTRL_ABORT_EN only)
module universal_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int SEL_W = 3,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [SEL_W-1:0] cmd_mode,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             sr_enable,
    output logic             sr_l_s,
    output logic [SEL_W-1:0] sr_selector,
    output logic [WIDTH-1:0] sr_inp,
    input  logic [WIDTH-1:0] sr_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
`ifdef UNIV_CTRL_ABORT_EN
    ,
    input  logic             abort,
    output logic             rsp_aborted
`endif
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SHIFT   = 3'd2,
        CAPTURE = 3'd3,
        RESP    = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   mode_q, mode_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic               active;
    logic               abort_hit;

    // Register is driven only in LOAD and SHIFT.
    assign active = (state_q == LOAD) || (state_q == SHIFT);

`ifdef UNIV_CTRL_ABORT_EN
    logic aborted_q, aborted_d;
    // Only input-to-output combinational path: abort gates the enable.
    assign abort_hit   = abort && active;
    assign rsp_aborted = aborted_q;
`else
    assign abort_hit   = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        data_d     = data_q;
        rem_d      = rem_q;
        rsp_data_d = rsp_data_q;
`ifdef UNIV_CTRL_ABORT_EN
        aborted_d  = aborted_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    mode_d  = cmd_mode;
                    data_d  = cmd_data;
                    rem_d   = cmd_count;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (abort_hit)
                    state_d = CAPTURE;
                else if (rem_q != '0)
                    state_d = SHIFT;
                else
                    state_d = CAPTURE;
            end
            SHIFT: begin
                if (abort_hit) begin
                    state_d = CAPTURE;
                end else begin
                    rem_d = rem_q - 1'b1;
                    // Leaving on remaining==1 yields exactly `count` shifts.
                    if (rem_q == {{(CNT_W-1){1'b0}}, 1'b1})
                        state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                rsp_data_d = sr_out;
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
`ifdef UNIV_CTRL_ABORT_EN
                    aborted_d = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef UNIV_CTRL_ABORT_EN
        if (abort_hit)
            aborted_d = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            mode_q     <= '0;
            data_q     <= '0;
            rem_q      <= '0;
            rsp_data_q <= '0;
`ifdef UNIV_CTRL_ABORT_EN
            aborted_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            data_q     <= data_d;
            rem_q      <= rem_d;
            rsp_data_q <= rsp_data_d;
`ifdef UNIV_CTRL_ABORT_EN
            aborted_q  <= aborted_d;
`endif
        end
    end

    // State-decoded outputs: reset forces IDLE, so sr_enable drops at once.
    assign sr_enable   = active && !abort_hit;
    assign sr_l_s      = (state_q == LOAD);
    assign sr_selector = active ? mode_q : '0;
    assign sr_inp      = data_q;
    assign rsp_valid   = (state_q == RESP);
    assign rsp_data    = rsp_data_q;
    assign busy        = (state_q != IDLE);
    assign cmd_ready   = (state_q == IDLE);

endmodule

// File: tb/tb_universal_seq_ctrl.sv
// Directed bench for universal_seq_ctrl with a behavioural shift register
// model on the sr_* side (mode 1 = shift right, mode 2 = shift left, else hold).
module tb_universal_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready;
    logic [2:0] cmd_mode;
    logic [3:0] cmd_data;
    logic [3:0] cmd_count;
    logic       sr_enable, sr_l_s;
    logic [2:0] sr_selector;
    logic [3:0] sr_inp, sr_out;
    logic       rsp_valid, rsp_ready;
    logic [3:0] rsp_data;
    logic       busy;
`ifdef UNIV_CTRL_ABORT_EN
    logic       abort = 1'b0;
    logic       rsp_aborted;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int n_loads = 0;
    int n_shifts = 0;
    int snap;

    logic [3:0] sr_reg = 4'h0;
    assign sr_out = sr_reg;

    always #5 clk = ~clk;

    universal_seq_ctrl #(.WIDTH(4), .SEL_W(3), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_data(cmd_data), .cmd_count(cmd_count),
        .sr_enable(sr_enable), .sr_l_s(sr_l_s), .sr_selector(sr_selector),
        .sr_inp(sr_inp), .sr_out(sr_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy)
`ifdef UNIV_CTRL_ABORT_EN
        , .abort(abort), .rsp_aborted(rsp_aborted)
`endif
    );

    // Shift register model; not reset by rst (contents survive a reset).
    always @(posedge clk) begin
        if (sr_enable) begin
            if (sr_l_s) begin
                sr_reg  <= sr_inp;
                n_loads <= n_loads + 1;
            end else begin
                case (sr_selector)
                    3'd1:    sr_reg <= {1'b0, sr_reg[3:1]};
                    3'd2:    sr_reg <= {sr_reg[2:0], 1'b0};
                    default: sr_reg <= sr_reg;
                endcase
                n_shifts <= n_shifts + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nedge();
        @(negedge clk);
    endtask

    initial begin
        // ---- 1. reset with cmd_valid held high ----
        rst = 1'b0; cmd_valid = 1'b1; cmd_mode = 3'd5; cmd_data = 4'h9;
        cmd_count = 4'd2; rsp_ready = 1'b0;
        repeat (3) nedge();
        chk("rst_en",    sr_enable,   0);
        chk("rst_ls",    sr_l_s,      0);
        chk("rst_sel",   sr_selector, 0);
        chk("rst_inp",   sr_inp,      0);
        chk("rst_rv",    rsp_valid,   0);
        chk("rst_rd",    rsp_data,    0);
        chk("rst_busy",  busy,        0);
        chk("rst_ready", cmd_ready,   1);
        chk("rst_noload", n_loads,    0);
        cmd_valid = 1'b0;
        rst = 1'b1;
        nedge();
        chk("idle_ready", cmd_ready, 1);

        // ---- 2. load only ----
        cmd_valid = 1'b1; cmd_mode = 3'd2; cmd_data = 4'd13; cmd_count = 4'd0;
        nedge();
        cmd_valid = 1'b0;
        chk("ld_en",   sr_enable,   1);
        chk("ld_ls",   sr_l_s,      1);
        chk("ld_sel",  sr_selector, 2);
        chk("ld_inp",  sr_inp,      13);
        chk("ld_busy", busy,        1);
        chk("ld_rdy",  cmd_ready,   0);
        nedge();
        chk("ld_cap_en", sr_enable, 0);
        chk("ld_cap_rv", rsp_valid, 0);
        chk("ld_cap_sel", sr_selector, 0);
        chk("ld_cap_inp", sr_inp, 13);
        nedge();
        chk("ld_rv", rsp_valid, 1);
        chk("ld_rd", rsp_data,  13);
        rsp_ready = 1'b1;
        nedge();
        rsp_ready = 1'b0;
        chk("ld_done_rv",  rsp_valid, 0);
        chk("ld_done_rdy", cmd_ready, 1);

        // ---- 3. shift run: 1101 >> 3 = 0001 ----
        snap = n_shifts;
        cmd_valid = 1'b1; cmd_mode = 3'd1; cmd_data = 4'd13; cmd_count = 4'd3;
        nedge();
        cmd_valid = 1'b0;
        chk("sh_load", {sr_enable, sr_l_s}, 2'b11);
        for (int i = 0; i < 3; i++) begin
            nedge();
            chk("sh_cyc", {sr_enable, sr_l_s, sr_selector}, 5'b10_001);
        end
        nedge();
        chk("sh_cap_en", sr_enable, 0);
        chk("sh_cap_rv", rsp_valid, 0);
        nedge();
        chk("sh_rv", rsp_valid, 1);
        chk("sh_rd", rsp_data,  4'h1);
        chk("sh_count", n_shifts - snap, 3);

        // ---- 4. backpressure, new command waiting ----
        snap = n_loads;
        cmd_valid = 1'b1; cmd_mode = 3'd2; cmd_data = 4'd6; cmd_count = 4'd1;
        for (int i = 0; i < 10; i++) begin
            nedge();
            chk("bp_hold", {rsp_valid, rsp_data, cmd_ready, sr_enable}, {1'b1, 4'h1, 1'b0, 1'b0});
        end
        chk("bp_noload", n_loads - snap, 0);
        rsp_ready = 1'b1;
        nedge();
        rsp_ready = 1'b0;
        chk("bp_idle_rv",  rsp_valid, 0);
        chk("bp_idle_rdy", cmd_ready, 1);
        chk("bp_idle_en",  sr_enable, 0);
        nedge();
        cmd_valid = 1'b0;
        chk("bp_load", {sr_enable, sr_l_s, sr_selector, sr_inp}, {1'b1, 1'b1, 3'd2, 4'd6});
        nedge();
        chk("bp_shift", {sr_enable, sr_l_s}, 2'b10);
        nedge();
        chk("bp_cap", sr_enable, 0);
        nedge();
        chk("bp_rv", rsp_valid, 1);
        chk("bp_rd", rsp_data, 4'hC);   // 0110 << 1
        rsp_ready = 1'b1;
        nedge();
        rsp_ready = 1'b0;

        // ---- 5. reset in 2nd shift cycle ----
        cmd_valid = 1'b1; cmd_mode = 3'd1; cmd_data = 4'hF; cmd_count = 4'd15;
        nedge();
        cmd_valid = 1'b0;
        nedge();            // 1st shift cycle
        nedge();            // 2nd shift cycle
        chk("mr_pre_en", sr_enable, 1);
        rst = 1'b0;
        #1;
        chk("mr_en",   sr_enable, 0);
        chk("mr_busy", busy,      0);
        chk("mr_rv",   rsp_valid, 0);
        nedge();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            nedge();
            chk("mr_norsp", {rsp_valid, busy}, 2'b00);
        end
        // register left at 1111>>1 = 0111; reload with 3 then shift left
        cmd_valid = 1'b1; cmd_mode = 3'd2; cmd_data = 4'd3; cmd_count = 4'd1;
        nedge();
        cmd_valid = 1'b0;
        chk("mr2_load", {sr_enable, sr_l_s}, 2'b11);
        nedge();
        nedge();
        nedge();
        chk("mr2_rv", rsp_valid, 1);
        chk("mr2_rd", rsp_data, 4'h6);
        rsp_ready = 1'b1;
        nedge();
        rsp_ready = 1'b0;
        chk("mr2_idle", cmd_ready, 1);

`ifdef UNIV_CTRL_ABORT_EN
        // ---- 6. abort in 4th shift cycle: 1000 >> 3 = 0001 ----
        snap = n_shifts;
        cmd_valid = 1'b1; cmd_mode = 3'd1; cmd_data = 4'h8; cmd_count = 4'd15;
        nedge();
        cmd_valid = 1'b0;
        repeat (4) nedge();
        abort = 1'b1;
        #1;
        chk("ab_en", sr_enable, 0);
        nedge();
        abort = 1'b0;
        chk("ab_cap", {sr_enable, rsp_valid}, 2'b00);
        nedge();
        chk("ab_rv",  rsp_valid,   1);
        chk("ab_flg", rsp_aborted, 1);
        chk("ab_rd",  rsp_data,    4'h1);
        chk("ab_cnt", n_shifts - snap, 3);
        rsp_ready = 1'b1;
        nedge();
        rsp_ready = 1'b0;
        chk("ab_clr", rsp_aborted, 0);
        chk("ab_idle", cmd_ready, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
